// File: rtl/stream_mux_rr.sv
// N-to-1 packet stream merge: round-robin arbitration, locked to the winning
// channel until its last beat, with a one-entry output register tagged by source.
module stream_mux_rr #(
   parameter int INPUTS     = 8,
   parameter int SEL_BITS   = $clog2(INPUTS),
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data [INPUTS],
   input  logic [INPUTS-1:0]     in_valid,
   input  logic [INPUTS-1:0]     in_last,
   output logic [INPUTS-1:0]     in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_last,
   output logic [SEL_BITS-1:0]   out_sel,
   input  logic                  out_ready
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [SEL_BITS-1:0]   grant_q, grant_d;
   logic [SEL_BITS-1:0]   ptr_q, ptr_d;
   logic [SEL_BITS-1:0]   pick_s;
   logic [SEL_BITS:0]     idx_s;
   logic                  any_req_s;
   logic                  can_load_s;
   logic                  load_s;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic [SEL_BITS-1:0]   sel_q, sel_d;

   // Rotating-priority search from ptr; the extra idx bit lets the wrap happen at INPUTS-1
   always_comb begin
      pick_s    = ptr_q;
      any_req_s = 1'b0;
      idx_s     = '0;
      for (int k = 0; k < INPUTS; k++) begin
         idx_s     = {1'b0, ptr_q} + (SEL_BITS+1)'(k);
         idx_s     = (idx_s >= (SEL_BITS+1)'(INPUTS)) ? idx_s - (SEL_BITS+1)'(INPUTS) : idx_s;
         pick_s    = (!any_req_s && in_valid[idx_s[SEL_BITS-1:0]]) ? idx_s[SEL_BITS-1:0] : pick_s;
         any_req_s = any_req_s | in_valid[idx_s[SEL_BITS-1:0]];
      end
   end

   // Arbitration FSM next state and per-channel ready
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      in_ready   = '0;
      can_load_s = !valid_q || out_ready;
      load_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               grant_d = pick_s;
               state_d = ST_LOCK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCK: begin
            in_ready[grant_q] = can_load_s;
            load_s            = can_load_s && in_valid[grant_q];
            if (load_s && in_last[grant_q]) begin
               state_d = ST_IDLE;
               ptr_d   = (grant_q == SEL_BITS'(INPUTS-1)) ? '0 : grant_q + SEL_BITS'(1);
            end else begin
               state_d = ST_LOCK;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output register: load wins over drain so back-to-back beats keep valid high
   always_comb begin
      data_d  = data_q;
      last_d  = last_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      if (load_s) begin
         data_d  = in_data[grant_q];
         last_d  = in_last[grant_q];
         sel_d   = grant_q;
         valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign out_sel   = sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed packet scenarios plus random traffic, checked
// every cycle against a packet-level round-robin reference model.
module tb_stream_mux_rr;

   localparam int N = 8;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic       last;
   } exp_t;

   typedef struct {
      int         cyc;
      int         sel;
      logic [7:0] data;
      logic       last;
   } obs_t;

   logic         clk;
   logic         rst_n;
   logic [7:0]   din [N];
   logic [N-1:0] vin;
   logic [N-1:0] lin;
   logic [N-1:0] in_ready;
   logic [7:0]   out_data;
   logic         out_valid;
   logic         out_last;
   logic [2:0]   out_sel;
   logic         ordy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   beat_t chan_q [N][$];
   exp_t  exp_q [$];
   obs_t  obs_q [$];
   obs_t  ob;
   exp_t  ex;

   logic [N-1:0] xfer_mask = '0;
   bit           m_busy = 1'b0;
   bit           m_ov   = 1'b0;
   int           m_owner = 0;
   int           m_ptr   = 0;
   bit           m_found;
   bit           m_in_x;
   bit           m_out_x;
   logic [N-1:0] m_exp_rdy;

   bit stall_en  = 1'b0;
   bit ordy_rand = 1'b0;
   bit ordy_man  = 1'b1;

   stream_mux_rr #(.INPUTS(N), .DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (din),
      .in_valid  (vin),
      .in_last   (lin),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_sel   (out_sel),
      .out_ready (ordy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference model: whole packets from one channel at a time, next channel
   // chosen round-robin after the last owner, one output slot that drains on ready.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            m_busy = 1'b0;
            m_ov   = 1'b0;
            m_ptr  = 0;
            exp_q.delete();
            xfer_mask = '0;
            check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check_eq("rst_in_ready", {24'd0, in_ready}, 32'd0);
            check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
            check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
            check_eq("rst_out_sel", {29'd0, out_sel}, 32'd0);
         end else begin
            m_exp_rdy = '0;
            if (m_busy && (!m_ov || ordy)) m_exp_rdy[m_owner] = 1'b1;
            check_eq("in_ready", {24'd0, in_ready}, {24'd0, m_exp_rdy});
            check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            if (m_ov) begin
               check_eq("out_data", {24'd0, out_data}, {24'd0, exp_q[0].data});
               check_eq("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
               check_eq("out_sel", {29'd0, out_sel}, exp_q[0].sel);
            end
            m_in_x  = m_busy && m_exp_rdy[m_owner] && vin[m_owner];
            m_out_x = m_ov && ordy;
            xfer_mask = '0;
            if (m_out_x) begin
               ob.cyc  = cyc;
               ob.sel  = exp_q[0].sel;
               ob.data = out_data;
               ob.last = out_last;
               obs_q.push_back(ob);
               void'(exp_q.pop_front());
            end
            if (m_in_x) begin
               ex.sel  = m_owner;
               ex.data = din[m_owner];
               ex.last = lin[m_owner];
               exp_q.push_back(ex);
               xfer_mask[m_owner] = 1'b1;
            end
            m_ov = (m_ov && !m_out_x) || m_in_x;
            if (m_busy) begin
               if (m_in_x && lin[m_owner]) begin
                  m_busy = 1'b0;
                  m_ptr  = (m_owner + 1) % N;
               end
            end else if (vin != '0) begin
               m_found = 1'b0;
               for (int k = 0; k < N; k++) begin
                  if (!m_found && vin[(m_ptr + k) % N]) begin
                     m_found = 1'b1;
                     m_owner = (m_ptr + k) % N;
                  end
               end
               m_busy = 1'b1;
            end
         end
      end
   end

   task automatic tick();
      bit hold;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (xfer_mask[i] && chan_q[i].size() > 0) void'(chan_q[i].pop_front());
         hold = stall_en && m_busy && (m_owner == i) && ($urandom_range(0, 3) == 0);
         if (chan_q[i].size() > 0 && !hold) begin
            vin[i] = 1'b1;
            din[i] = chan_q[i][0].data;
            lin[i] = chan_q[i][0].last;
         end else begin
            vin[i] = 1'b0;
            din[i] = 8'd0;
            lin[i] = 1'b0;
         end
      end
      ordy = ordy_rand ? ($urandom_range(0, 3) != 0) : ordy_man;
   endtask

   task automatic push_pkt(input int ch, input int len, input logic [7:0] base);
      beat_t b;
      for (int j = 0; j < len; j++) begin
         b.data = base + 8'(j);
         b.last = (j == len - 1);
         chan_q[ch].push_back(b);
      end
   endtask

   function automatic bit all_quiet();
      bit q;
      q = !m_busy && !m_ov;
      for (int i = 0; i < N; i++) if (chan_q[i].size() != 0) q = 1'b0;
      return q;
   endfunction

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while (!all_quiet() && n < max_cyc) begin
         tick();
         n++;
      end
      if (!all_quiet()) check_eq("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic check_seq(input string tag, input int base, input int cnt,
                            input int sel_exp [], input int dat_exp []);
      check_eq({tag, "_count"}, obs_q.size() - base, cnt);
      for (int j = 0; j < cnt; j++) begin
         if (obs_q.size() > base + j) begin
            check_eq({tag, "_sel"}, obs_q[base+j].sel, sel_exp[j]);
            check_eq({tag, "_data"}, {24'd0, obs_q[base+j].data}, dat_exp[j]);
         end
      end
   endtask

   int base;
   int c0;
   int n;
   int sel_e [];
   int dat_e [];

   initial begin
      rst_n = 1'b1;
      vin   = '0;
      lin   = '0;
      ordy  = 1'b1;
      for (int i = 0; i < N; i++) din[i] = 8'd0;
      #2 rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Ch2 alone, 3-beat packet: beats at c+2..c+4, last only on the third
      base = obs_q.size();
      push_pkt(2, 3, 8'hA1);
      tick();
      c0 = cyc + 1;
      drain(50);
      check_eq("t2_count", obs_q.size() - base, 3);
      for (int j = 0; j < 3; j++) begin
         if (obs_q.size() > base + j) begin
            check_eq("t2_data", {24'd0, obs_q[base+j].data}, 32'hA1 + j);
            check_eq("t2_sel", obs_q[base+j].sel, 2);
            check_eq("t2_last", {31'd0, obs_q[base+j].last}, (j == 2) ? 32'd1 : 32'd0);
            check_eq("t2_cycle", obs_q[base+j].cyc, c0 + 2 + j);
         end
      end

      // Ch0, ch3, ch7 single-beat packets from reset; ch0 has a second one queued
      do_reset();
      base = obs_q.size();
      push_pkt(0, 1, 8'h10);
      push_pkt(0, 1, 8'h11);
      push_pkt(3, 1, 8'h30);
      push_pkt(7, 1, 8'h70);
      drain(60);
      sel_e = '{0, 3, 7, 0};
      dat_e = '{'h10, 'h30, 'h70, 'h11};
      check_seq("t3", base, 4, sel_e, dat_e);

      // Ch7 ends a packet, pointer wraps so ch0 beats ch5
      push_pkt(7, 1, 8'h77);
      drain(30);
      base = obs_q.size();
      push_pkt(5, 1, 8'h55);
      push_pkt(0, 1, 8'h05);
      drain(30);
      sel_e = '{0, 5};
      dat_e = '{'h05, 'h55};
      check_seq("t4", base, 2, sel_e, dat_e);

      // Backpressure for 4 cycles mid-packet
      base = obs_q.size();
      push_pkt(1, 4, 8'hB0);
      n = 0;
      while (obs_q.size() == base && n < 20) begin
         tick();
         n++;
      end
      check_eq("t5_started", {31'd0, obs_q.size() > base}, 32'd1);
      ordy_man = 1'b0;
      for (int j = 0; j < 4; j++) begin
         tick();
         #1;
         check_eq("t5_stall_ready", {24'd0, in_ready}, 32'd0);
         check_eq("t5_stall_valid", {31'd0, out_valid}, 32'd1);
      end
      ordy_man = 1'b1;
      drain(40);
      sel_e = '{1, 1, 1, 1};
      dat_e = '{'hB0, 'hB1, 'hB2, 'hB3};
      check_seq("t5", base, 4, sel_e, dat_e);

      // Ch1 locked; ch4 shows up mid-packet and waits its turn
      base = obs_q.size();
      push_pkt(1, 3, 8'hC0);
      tick();
      tick();
      push_pkt(4, 1, 8'h44);
      drain(40);
      sel_e = '{1, 1, 1, 4};
      dat_e = '{'hC0, 'hC1, 'hC2, 'h44};
      check_seq("t6", base, 4, sel_e, dat_e);

      // Reset while a beat sits in the output register
      ordy_man = 1'b0;
      push_pkt(5, 4, 8'hD0);
      n = 0;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      check_eq("t1_loaded", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("t1_async_valid", {31'd0, out_valid}, 32'd0);
      check_eq("t1_async_ready", {24'd0, in_ready}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      check_eq("t1_release_ready", {24'd0, in_ready}, 32'd0);
      ordy_man = 1'b1;
      drain(40);

      // Random traffic with source stalls and output backpressure
      stall_en  = 1'b1;
      ordy_rand = 1'b1;
      for (int t = 0; t < 2500; t++) begin
         for (int i = 0; i < N; i++) begin
            if (chan_q[i].size() == 0 && $urandom_range(0, 7) == 0)
               push_pkt(i, $urandom_range(1, 4), 8'($urandom_range(0, 255)));
         end
         tick();
      end
      stall_en  = 1'b0;
      ordy_rand = 1'b0;
      ordy_man  = 1'b1;
      drain(400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
